// File: rtl/fetch_ctrl_if.sv
// Fetch-stage bundle: redirect input, instruction-memory port and decode handshake.
// master is the fetch_ctrl side, slave is the memory/execute/decode environment.
interface fetch_ctrl_if #(
    parameter int AddrSize  = 32,
    parameter int InstrSize = 32
);
    logic                 redirect_i;
    logic [AddrSize-1:0]  redirect_pc_i;
    logic                 imem_req_o;
    logic [AddrSize-1:0]  imem_addr_o;
    logic                 imem_gnt_i;
    logic                 imem_rvalid_i;
    logic [InstrSize-1:0] imem_rdata_i;
    logic                 instr_valid_o;
    logic [InstrSize-1:0] instr_o;
    logic [AddrSize-1:0]  instr_pc_o;
    logic                 instr_ready_i;

    modport master (
        input  redirect_i, redirect_pc_i, imem_gnt_i, imem_rvalid_i, imem_rdata_i, instr_ready_i,
        output imem_req_o, imem_addr_o, instr_valid_o, instr_o, instr_pc_o
    );

    modport slave (
        output redirect_i, redirect_pc_i, imem_gnt_i, imem_rvalid_i, imem_rdata_i, instr_ready_i,
        input  imem_req_o, imem_addr_o, instr_valid_o, instr_o, instr_pc_o
    );
endinterface

// File: rtl/fetch_ctrl.sv
// Fetch sequencer: owns the PC, issues one instruction-memory request at a time
// and hands each response to decode, discarding responses made stale by a redirect.
//
// state | meaning
// IDLE  | leaving reset, request next cycle
// REQ   | imem_req_o high, waiting for grant
// WAIT  | granted, waiting for rvalid (dropped if kill_q)
// HOLD  | instruction presented to decode, waiting for ready
module fetch_ctrl #(
    parameter int                  AddrSize  = 32,
    parameter int                  InstrSize = 32,
    parameter logic [AddrSize-1:0] ResetPc   = '0,
    parameter int                  IncStep   = 4
) (
    input  logic          clk_i,
    input  logic          rst_i,
    fetch_ctrl_if.master  bus
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_t;

    localparam logic [AddrSize-1:0] Step = AddrSize'(IncStep);

    state_t               state_q, state_d;
    logic [AddrSize-1:0]  pc_q, pc_d;
    logic [AddrSize-1:0]  addr_q, addr_d;
    logic [AddrSize-1:0]  ipc_q, ipc_d;
    logic [InstrSize-1:0] instr_q, instr_d;
    logic                 kill_q, kill_d;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
            pc_q    <= ResetPc;
            addr_q  <= ResetPc;
            ipc_q   <= '0;
            instr_q <= '0;
            kill_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            addr_q  <= addr_d;
            ipc_q   <= ipc_d;
            instr_q <= instr_d;
            kill_q  <= kill_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ipc_d   = ipc_q;
        instr_d = instr_q;
        kill_d  = kill_q;

        case (state_q)
            IDLE: state_d = REQ;
            REQ: begin
                if (bus.imem_gnt_i) state_d = WAIT;
                if (bus.redirect_i) kill_d = 1'b1;
            end
            WAIT: begin
                if (bus.imem_rvalid_i) begin
                    if (kill_q || bus.redirect_i) begin
                        kill_d  = 1'b0;
                        state_d = REQ;
                    end else begin
                        instr_d = bus.imem_rdata_i;
                        ipc_d   = pc_q;
                        state_d = HOLD;
                    end
                end else if (bus.redirect_i) begin
                    kill_d = 1'b1;
                end
            end
            HOLD: begin
                if (bus.redirect_i) begin
                    state_d = REQ;
                end else if (bus.instr_ready_i) begin
                    pc_d    = pc_q + Step;
                    state_d = REQ;
                end
            end
            default: state_d = IDLE;
        endcase

        if (bus.redirect_i) pc_d = bus.redirect_pc_i;

        // An ungranted request keeps its address even when a redirect moves pc_q;
        // that request is then killed and the target is fetched afterwards.
        addr_d = (state_q == REQ && !bus.imem_gnt_i) ? addr_q : pc_d;
    end

    assign bus.imem_req_o    = (state_q == REQ);
    assign bus.imem_addr_o   = addr_q;
    assign bus.instr_valid_o = (state_q == HOLD);
    assign bus.instr_o       = instr_q;
    assign bus.instr_pc_o    = ipc_q;
endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: directed scenarios plus a randomized run
// checked against a program-order model of the expected PC stream.
module tb_fetch_ctrl;
    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   failures = 0;

    fetch_ctrl_if #(.AddrSize(32), .InstrSize(32)) bus ();
    fetch_ctrl_if #(.AddrSize(8),  .InstrSize(32)) bus8 ();

    fetch_ctrl #(.AddrSize(32), .InstrSize(32), .ResetPc(32'h0), .IncStep(4)) dut (
        .clk_i(clk), .rst_i(rst_n), .bus(bus));
    fetch_ctrl #(.AddrSize(8), .InstrSize(32), .ResetPc(8'h0), .IncStep(4)) dut8 (
        .clk_i(clk), .rst_i(rst_n), .bus(bus8));

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_f(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hC0DE_0001;
    endfunction

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        bus.redirect_i = 1'b0;     bus.redirect_pc_i = '0;
        bus.imem_gnt_i = 1'b0;     bus.imem_rvalid_i = 1'b0;
        bus.imem_rdata_i = '0;     bus.instr_ready_i = 1'b0;
        bus8.redirect_i = 1'b0;    bus8.redirect_pc_i = '0;
        bus8.imem_gnt_i = 1'b0;    bus8.imem_rvalid_i = 1'b0;
        bus8.imem_rdata_i = '0;    bus8.instr_ready_i = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle_inputs();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle_inputs();
        @(negedge clk);
        checks++; if (bus.imem_req_o !== 1'b0) begin failures++; $display("FAIL reset_req got=%b exp=0", bus.imem_req_o); end
        checks++; if (bus.instr_valid_o !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", bus.instr_valid_o); end
        checks++; if (bus.imem_addr_o !== 32'h0) begin failures++; $display("FAIL reset_addr got=%h exp=0", bus.imem_addr_o); end
        checks++; if (bus.instr_o !== 32'h0) begin failures++; $display("FAIL reset_instr got=%h exp=0", bus.instr_o); end
        checks++; if (bus.instr_pc_o !== 32'h0) begin failures++; $display("FAIL reset_ipc got=%h exp=0", bus.instr_pc_o); end
        rst_n = 1'b1;
        @(negedge clk);
        step();
        checks++; if (bus.imem_req_o !== 1'b1 || bus.imem_addr_o !== 32'h0)
            begin failures++; $display("FAIL first_req got=%b/%h exp=1/0", bus.imem_req_o, bus.imem_addr_o); end
    endtask

    task automatic test_sequential();
        logic [31:0] a;
        bus.instr_ready_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            a = 32'(4 * i);
            checks++; if (bus.imem_req_o !== 1'b1 || bus.imem_addr_o !== a || bus.instr_valid_o !== 1'b0)
                begin failures++; $display("FAIL seq_req got=%b/%h exp=1/%h", bus.imem_req_o, bus.imem_addr_o, a); end
            bus.imem_gnt_i = 1'b1;
            step();
            bus.imem_gnt_i = 1'b0;
            bus.imem_rvalid_i = 1'b1; bus.imem_rdata_i = mem_f(a);
            checks++; if (bus.imem_req_o !== 1'b0 || bus.instr_valid_o !== 1'b0)
                begin failures++; $display("FAIL seq_wait got=%b/%b exp=0/0", bus.imem_req_o, bus.instr_valid_o); end
            step();
            bus.imem_rvalid_i = 1'b0;
            checks++; if (bus.instr_valid_o !== 1'b1 || bus.instr_pc_o !== a || bus.instr_o !== mem_f(a) || bus.imem_req_o !== 1'b0)
                begin failures++; $display("FAIL seq_hold got=%b/%h/%h exp=1/%h/%h", bus.instr_valid_o, bus.instr_pc_o, bus.instr_o, a, mem_f(a)); end
            step();
        end
    endtask

    task automatic test_backpressure();
        bus.instr_ready_i = 1'b0;
        bus.imem_gnt_i = 1'b1;
        step();
        bus.imem_gnt_i = 1'b0;
        bus.imem_rvalid_i = 1'b1; bus.imem_rdata_i = mem_f(32'hC);
        step();
        bus.imem_rvalid_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            checks++; if (bus.instr_valid_o !== 1'b1 || bus.instr_pc_o !== 32'hC || bus.instr_o !== mem_f(32'hC) || bus.imem_req_o !== 1'b0)
                begin failures++; $display("FAIL bp_hold cyc=%0d got=%b/%h/%h/%b exp=1/c/%h/0", i, bus.instr_valid_o, bus.instr_pc_o, bus.instr_o, bus.imem_req_o, mem_f(32'hC)); end
            step();
        end
        bus.instr_ready_i = 1'b1;
        step();
        checks++; if (bus.imem_req_o !== 1'b1 || bus.imem_addr_o !== 32'h10)
            begin failures++; $display("FAIL bp_next got=%b/%h exp=1/10", bus.imem_req_o, bus.imem_addr_o); end
    endtask

    task automatic test_gnt_delay();
        for (int i = 0; i < 4; i++) begin
            checks++; if (bus.imem_req_o !== 1'b1 || bus.imem_addr_o !== 32'h10)
                begin failures++; $display("FAIL gnt_delay cyc=%0d got=%b/%h exp=1/10", i, bus.imem_req_o, bus.imem_addr_o); end
            step();
        end
        bus.imem_gnt_i = 1'b1;
        step();
        bus.imem_gnt_i = 1'b0;
        bus.imem_rvalid_i = 1'b1; bus.imem_rdata_i = mem_f(32'h10);
        step();
        bus.imem_rvalid_i = 1'b0;
        checks++; if (bus.instr_valid_o !== 1'b1 || bus.instr_pc_o !== 32'h10 || bus.instr_o !== mem_f(32'h10))
            begin failures++; $display("FAIL gnt_delay_hold got=%b/%h/%h exp=1/10/%h", bus.instr_valid_o, bus.instr_pc_o, bus.instr_o, mem_f(32'h10)); end
        step();
    endtask

    task automatic test_redirect_wait();
        bus.imem_gnt_i = 1'b1;
        step();
        bus.imem_gnt_i = 1'b0;
        bus.redirect_i = 1'b1; bus.redirect_pc_i = 32'h100;
        step();
        bus.redirect_i = 1'b0;
        checks++; if (bus.instr_valid_o !== 1'b0) begin failures++; $display("FAIL rw_wait1 valid got=%b exp=0", bus.instr_valid_o); end
        step();
        bus.imem_rvalid_i = 1'b1; bus.imem_rdata_i = 32'hDEAD;
        step();
        bus.imem_rvalid_i = 1'b0;
        checks++; if (bus.instr_valid_o !== 1'b0 || bus.imem_req_o !== 1'b1 || bus.imem_addr_o !== 32'h100)
            begin failures++; $display("FAIL rw_next got=%b/%b/%h exp=0/1/100", bus.instr_valid_o, bus.imem_req_o, bus.imem_addr_o); end
        bus.imem_gnt_i = 1'b1;
        step();
        bus.imem_gnt_i = 1'b0;
        bus.imem_rvalid_i = 1'b1; bus.imem_rdata_i = mem_f(32'h100);
        step();
        bus.imem_rvalid_i = 1'b0;
        checks++; if (bus.instr_valid_o !== 1'b1 || bus.instr_pc_o !== 32'h100 || bus.instr_o !== mem_f(32'h100))
            begin failures++; $display("FAIL rw_hold got=%b/%h/%h exp=1/100/%h", bus.instr_valid_o, bus.instr_pc_o, bus.instr_o, mem_f(32'h100)); end
        step();
    endtask

    task automatic test_redirect_hold();
        bus.instr_ready_i = 1'b0;
        bus.imem_gnt_i = 1'b1;
        step();
        bus.imem_gnt_i = 1'b0;
        bus.imem_rvalid_i = 1'b1; bus.imem_rdata_i = mem_f(32'h104);
        step();
        bus.imem_rvalid_i = 1'b0;
        checks++; if (bus.instr_valid_o !== 1'b1 || bus.instr_pc_o !== 32'h104)
            begin failures++; $display("FAIL rh_hold got=%b/%h exp=1/104", bus.instr_valid_o, bus.instr_pc_o); end
        bus.instr_ready_i = 1'b1;
        bus.redirect_i = 1'b1; bus.redirect_pc_i = 32'h200;
        step();
        bus.redirect_i = 1'b0;
        checks++; if (bus.instr_valid_o !== 1'b0 || bus.imem_req_o !== 1'b1 || bus.imem_addr_o !== 32'h200)
            begin failures++; $display("FAIL rh_next got=%b/%b/%h exp=0/1/200", bus.instr_valid_o, bus.imem_req_o, bus.imem_addr_o); end
        bus.imem_gnt_i = 1'b1;
        step();
        bus.imem_gnt_i = 1'b0;
        bus.imem_rvalid_i = 1'b1; bus.imem_rdata_i = mem_f(32'h200);
        step();
        bus.imem_rvalid_i = 1'b0;
        checks++; if (bus.instr_valid_o !== 1'b1 || bus.instr_pc_o !== 32'h200 || bus.instr_o !== mem_f(32'h200))
            begin failures++; $display("FAIL rh_fetch got=%b/%h/%h exp=1/200/%h", bus.instr_valid_o, bus.instr_pc_o, bus.instr_o, mem_f(32'h200)); end
        step();
    endtask

    task automatic test_redirect_req();
        bus.redirect_i = 1'b1; bus.redirect_pc_i = 32'h300;
        step();
        bus.redirect_i = 1'b0;
        for (int i = 0; i < 2; i++) begin
            checks++; if (bus.imem_req_o !== 1'b1 || bus.imem_addr_o !== 32'h204)
                begin failures++; $display("FAIL rq_stable cyc=%0d got=%b/%h exp=1/204", i, bus.imem_req_o, bus.imem_addr_o); end
            if (i == 0) step();
        end
        bus.imem_gnt_i = 1'b1;
        step();
        bus.imem_gnt_i = 1'b0;
        bus.imem_rvalid_i = 1'b1; bus.imem_rdata_i = mem_f(32'h204);
        step();
        bus.imem_rvalid_i = 1'b0;
        checks++; if (bus.instr_valid_o !== 1'b0 || bus.imem_req_o !== 1'b1 || bus.imem_addr_o !== 32'h300)
            begin failures++; $display("FAIL rq_next got=%b/%b/%h exp=0/1/300", bus.instr_valid_o, bus.imem_req_o, bus.imem_addr_o); end
        bus.imem_gnt_i = 1'b1;
        step();
        bus.imem_gnt_i = 1'b0;
        bus.imem_rvalid_i = 1'b1; bus.imem_rdata_i = mem_f(32'h300);
        step();
        bus.imem_rvalid_i = 1'b0;
        checks++; if (bus.instr_valid_o !== 1'b1 || bus.instr_pc_o !== 32'h300 || bus.instr_o !== mem_f(32'h300))
            begin failures++; $display("FAIL rq_fetch got=%b/%h/%h exp=1/300/%h", bus.instr_valid_o, bus.instr_pc_o, bus.instr_o, mem_f(32'h300)); end
        step();
    endtask

    task automatic test_wrap();
        bus8.redirect_i = 1'b1; bus8.redirect_pc_i = 8'hFC; bus8.imem_gnt_i = 1'b1;
        step();
        bus8.redirect_i = 1'b0; bus8.imem_gnt_i = 1'b0;
        bus8.imem_rvalid_i = 1'b1; bus8.imem_rdata_i = 32'h1111_1111;
        step();
        bus8.imem_rvalid_i = 1'b0;
        checks++; if (bus8.imem_req_o !== 1'b1 || bus8.imem_addr_o !== 8'hFC || bus8.instr_valid_o !== 1'b0)
            begin failures++; $display("FAIL wrap_req got=%b/%h exp=1/fc", bus8.imem_req_o, bus8.imem_addr_o); end
        bus8.imem_gnt_i = 1'b1;
        step();
        bus8.imem_gnt_i = 1'b0;
        bus8.imem_rvalid_i = 1'b1; bus8.imem_rdata_i = 32'h2222_2222;
        step();
        bus8.imem_rvalid_i = 1'b0;
        checks++; if (bus8.instr_valid_o !== 1'b1 || bus8.instr_pc_o !== 8'hFC || bus8.instr_o !== 32'h2222_2222)
            begin failures++; $display("FAIL wrap_hold got=%b/%h/%h exp=1/fc/22222222", bus8.instr_valid_o, bus8.instr_pc_o, bus8.instr_o); end
        bus8.instr_ready_i = 1'b1;
        step();
        bus8.instr_ready_i = 1'b0;
        checks++; if (bus8.imem_req_o !== 1'b1 || bus8.imem_addr_o !== 8'h00)
            begin failures++; $display("FAIL wrap_next got=%b/%h exp=1/00", bus8.imem_req_o, bus8.imem_addr_o); end
    endtask

    task automatic test_reset_mid();
        bus.imem_gnt_i = 1'b1;
        step();
        bus.imem_gnt_i = 1'b0;
        checks++; if (bus.imem_req_o !== 1'b0 || bus.instr_o === 32'h0)
            begin failures++; $display("FAIL rm_pre got=%b/%h exp=0/nonzero", bus.imem_req_o, bus.instr_o); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (bus.imem_req_o !== 1'b0 || bus.instr_valid_o !== 1'b0 || bus.imem_addr_o !== 32'h0 ||
                      bus.instr_o !== 32'h0 || bus.instr_pc_o !== 32'h0)
            begin failures++; $display("FAIL rm_outputs got=%b/%b/%h/%h/%h exp=0/0/0/0/0", bus.imem_req_o, bus.instr_valid_o, bus.imem_addr_o, bus.instr_o, bus.instr_pc_o); end
        @(negedge clk);
        rst_n = 1'b1;
        idle_inputs();
    endtask

    task automatic test_random(input int n_cycles);
        logic [31:0] exp_pc, pend_addr, prev_addr, prev_instr, prev_ipc;
        bit pend, prev_req, prev_gnt, prev_valid, prev_ready, prev_redir;
        int pend_dly, accepted;
        do_reset();
        exp_pc = 32'h0; pend = 1'b0; pend_dly = 0; accepted = 0; pend_addr = '0;
        prev_req = 1'b0; prev_gnt = 1'b0; prev_valid = 1'b0; prev_ready = 1'b0; prev_redir = 1'b0;
        prev_addr = '0; prev_instr = '0; prev_ipc = '0;
        for (int c = 0; c < n_cycles; c++) begin
            if (prev_req && !prev_gnt) begin
                checks++; if (bus.imem_req_o !== 1'b1 || bus.imem_addr_o !== prev_addr)
                    begin failures++; $display("FAIL rnd_req_hold cyc=%0d got=%b/%h exp=1/%h", c, bus.imem_req_o, bus.imem_addr_o, prev_addr); end
            end
            if (prev_valid && !prev_ready && !prev_redir) begin
                checks++; if (bus.instr_valid_o !== 1'b1 || bus.instr_o !== prev_instr || bus.instr_pc_o !== prev_ipc)
                    begin failures++; $display("FAIL rnd_valid_hold cyc=%0d got=%b/%h/%h exp=1/%h/%h", c, bus.instr_valid_o, bus.instr_o, bus.instr_pc_o, prev_instr, prev_ipc); end
            end
            checks++; if ((bus.imem_req_o & bus.instr_valid_o) !== 1'b0)
                begin failures++; $display("FAIL rnd_exclusive cyc=%0d got=%b/%b exp=not both", c, bus.imem_req_o, bus.instr_valid_o); end

            bus.imem_rvalid_i = 1'b0;
            bus.imem_rdata_i = $urandom;
            if (pend) begin
                if (pend_dly == 0) begin
                    bus.imem_rvalid_i = 1'b1;
                    bus.imem_rdata_i = mem_f(pend_addr);
                    pend = 1'b0;
                end else pend_dly--;
            end else if ($urandom_range(0, 9) == 0) begin
                bus.imem_rvalid_i = 1'b1;  // stray response with nothing outstanding
            end
            bus.imem_gnt_i = 1'b0;
            if (bus.imem_req_o === 1'b1 && $urandom_range(0, 1) == 1) begin
                bus.imem_gnt_i = 1'b1;
                checks++; if (pend)
                    begin failures++; $display("FAIL rnd_outstanding cyc=%0d got=2 exp=1", c); end
                pend = 1'b1; pend_addr = bus.imem_addr_o; pend_dly = int'($urandom_range(0, 3));
            end
            bus.instr_ready_i = ($urandom_range(0, 9) < 6);
            bus.redirect_i = ($urandom_range(0, 99) < 4);
            bus.redirect_pc_i = $urandom;

            if (bus.redirect_i) begin
                exp_pc = bus.redirect_pc_i;
            end else if (bus.instr_valid_o === 1'b1 && bus.instr_ready_i) begin
                checks++; if (bus.instr_pc_o !== exp_pc || bus.instr_o !== mem_f(exp_pc))
                    begin failures++; $display("FAIL rnd_accept cyc=%0d got=%h/%h exp=%h/%h", c, bus.instr_pc_o, bus.instr_o, exp_pc, mem_f(exp_pc)); end
                exp_pc = exp_pc + 32'h4;
                accepted++;
            end
            prev_req = bus.imem_req_o; prev_gnt = bus.imem_gnt_i; prev_addr = bus.imem_addr_o;
            prev_valid = bus.instr_valid_o; prev_ready = bus.instr_ready_i; prev_redir = bus.redirect_i;
            prev_instr = bus.instr_o; prev_ipc = bus.instr_pc_o;
            step();
        end
        checks++; if (accepted < 100)
            begin failures++; $display("FAIL rnd_progress got=%0d exp>=100", accepted); end
        idle_inputs();
    endtask

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        test_reset();
        test_sequential();
        test_backpressure();
        test_gnt_delay();
        test_redirect_wait();
        test_redirect_hold();
        test_redirect_req();
        test_wrap();
        test_reset_mid();
        test_random(3000);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end
endmodule
